udp_tx_arb: RTL and testbench
=============================

UDP_TX_ARB -- requirements
Module: udp_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester streams; legal values 2..8.
REQ-002 Parameter CNT_W, default 16, width of the accepted-packet counter.
REQ-003 clk  input  1  single clock; all state on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 s_tdata_in  input  8*NUM_REQ  requester payload bytes; requester i on bits [8i+7:8i].
REQ-006 s_tvalid_in  input  NUM_REQ  per-requester valid.
REQ-007 s_tlast_in  input  NUM_REQ  per-requester end-of-packet.
REQ-008 s_dest_port_in  input  16*NUM_REQ  per-requester UDP destination port; sampled only at grant.
REQ-009 s_tready_out  output  NUM_REQ  per-requester ready.
REQ-010 m_tdata_out  output  8  byte to the UDP transmit datapath.
REQ-011 m_tvalid_out  output  1  output valid.
REQ-012 m_tlast_out  output  1  output end-of-packet.
REQ-013 m_tready_in  input  1  downstream ready.
REQ-014 m_dest_port_out  output  16  destination port of the packet currently granted.
REQ-015 grant_out  output  NUM_REQ  one-hot grant; all zero when idle.
REQ-016 busy_out  output  1  high while in XFER.
REQ-017 pkt_cnt_out  output  CNT_W  count of packets fully accepted downstream.

Function
REQ-018 The FSM SHALL have two states: IDLE and XFER.
REQ-019 In IDLE, all s_tready_out and grant_out SHALL be 0, m_tvalid_out SHALL be 0, and m_tlast_out SHALL be 0.
REQ-020 In IDLE, when any s_tvalid_in bit is 1, the block SHALL register a one-hot grant to the first requester with tvalid high, searching from (last_grant+1) mod NUM_REQ upward with wrap, and SHALL enter XFER on the next edge.
REQ-021 At that same edge, m_dest_port_out SHALL latch the winning requester's s_dest_port_in and SHALL hold it until the next grant.
REQ-022 In XFER, m_tdata_out, m_tvalid_out and m_tlast_out SHALL combinationally equal the granted requester's inputs.
REQ-023 In XFER, s_tready_out[grant] SHALL equal m_tready_in, and all other s_tready_out bits SHALL be 0.
REQ-024 A beat transfers when m_tvalid_out and m_tready_in are both 1; non-granted requesters SHALL never transfer a beat.
REQ-025 The grant SHALL stay locked for the whole packet, whatever the other requests do, until a beat with m_tlast_out=1 transfers.
REQ-026 On the tlast transfer, the block SHALL store last_grant = grant, increment pkt_cnt_out (wrapping modulo 2^CNT_W), clear grant and return to IDLE.
REQ-027 There SHALL be exactly one idle bubble cycle between consecutive packets; grant latency from tvalid in IDLE is 1 cycle.
REQ-028 A granted requester deasserting tvalid mid-packet SHALL stall the output (m_tvalid_out=0) without losing the grant.
REQ-029 A single-beat packet (tvalid and tlast together) SHALL complete in one XFER cycle when m_tready_in=1.
REQ-030 A change on s_dest_port_in during XFER SHALL NOT affect m_dest_port_out.
REQ-031 If only one requester is active, it SHALL be granted repeatedly, with one bubble per packet.

Reset
REQ-032 While reset=1, the FSM SHALL be in IDLE, grant_out=0, m_dest_port_out=0, pkt_cnt_out=0, busy_out=0, and all stream outputs SHALL be 0.
REQ-033 last_grant SHALL reset to NUM_REQ-1, so that requester 0 has first priority after reset.
REQ-034 Reset asserted mid-packet SHALL abort the packet immediately; no tlast is emitted, and arbitration restarts from REQ-033 after release.

Verification
REQ-035 Reset release, then requesters 0 and 2 assert tvalid together -> grant_out=0001 one cycle later, port0 on m_dest_port_out; after port0's 3-byte packet, grant_out=0100 following one bubble.
REQ-036 All four requesters continuously valid with 2-byte packets -> grant order 0,1,2,3,0; pkt_cnt_out=5 after five tlast transfers.
REQ-037 m_tready_in toggles 1,0,1,0 during a 4-byte packet -> the 4 bytes appear in order with no duplication; s_tready_out[grant] mirrors m_tready_in.
REQ-038 Granted requester drops tvalid for 3 cycles mid-packet while requester 1 is valid -> the grant is held and requester 1 receives no tready until tlast.
REQ-039 Reset pulsed during byte 2 of a 5-byte packet from requester 3 -> all outputs 0 at once; the next grant goes to the lowest-index valid requester.
REQ-040 CNT_W=4 with 17 single-beat packets -> pkt_cnt_out wraps to 1.

Source files
------------

// File: rtl/udp_tx_arb.sv
// Round-robin, packet-locked arbiter that merges NUM_REQ byte streams into
// a single UDP transmit stream and latches each winner's destination port.
module udp_tx_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*NUM_REQ-1:0]    s_tdata_in,
    input  logic [NUM_REQ-1:0]      s_tvalid_in,
    input  logic [NUM_REQ-1:0]      s_tlast_in,
    input  logic [16*NUM_REQ-1:0]   s_dest_port_in,
    output logic [NUM_REQ-1:0]      s_tready_out,
    output logic [7:0]              m_tdata_out,
    output logic                    m_tvalid_out,
    output logic                    m_tlast_out,
    input  logic                    m_tready_in,
    output logic [15:0]             m_dest_port_out,
    output logic [NUM_REQ-1:0]      grant_out,
    output logic                    busy_out,
    output logic [CNT_W-1:0]        pkt_cnt_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [15:0]          dest_port_q, dest_port_d;
    logic [CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;

    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic                 last_beat;

    // Rotating priority search starting just after the previous winner
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % int'(NUM_REQ));
            if (!win_found && s_tvalid_in[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Stream mux: only the granted requester is connected while in XFER
    always_comb begin
        m_tdata_out  = '0;
        m_tvalid_out = 1'b0;
        m_tlast_out  = 1'b0;
        s_tready_out = '0;
        if (state_q == XFER) begin
            m_tdata_out  = s_tdata_in[{gidx_q, 3'b000} +: 8];
            m_tvalid_out = s_tvalid_in[gidx_q];
            m_tlast_out  = s_tlast_in[gidx_q];
            s_tready_out = grant_q & {NUM_REQ{m_tready_in}};
        end
    end

    assign last_beat = m_tvalid_out & m_tready_in & m_tlast_out;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        last_grant_d = last_grant_q;
        dest_port_d  = dest_port_q;
        pkt_cnt_d    = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = XFER;
                    gidx_d      = win_idx;
                    grant_d     = NUM_REQ'(1) << win_idx;
                    dest_port_d = s_dest_port_in[{win_idx, 4'b0000} +: 16];
                end
            end
            XFER: begin
                if (last_beat) begin
                    state_d      = IDLE;
                    grant_d      = '0;
                    last_grant_d = gidx_q;
                    pkt_cnt_d    = pkt_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_grant_q <= LAST_GRANT_RST;
            dest_port_q  <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_grant_q <= last_grant_d;
            dest_port_q  <= dest_port_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign grant_out       = grant_q;
    assign busy_out        = (state_q == XFER);
    assign m_dest_port_out = dest_port_q;
    assign pkt_cnt_out     = pkt_cnt_q;

endmodule

// File: tb/tb_udp_tx_arb.sv
// Directed bench for udp_tx_arb; a second instance with a 4-bit counter
// shares the stimulus to exercise counter wrap.
module tb_udp_tx_arb;

    localparam int unsigned N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [8*N-1:0]    s_tdata;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tlast;
    logic [16*N-1:0]   s_dest;
    logic              m_tready;

    logic [N-1:0]      s_tready;
    logic [7:0]        m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic [15:0]       m_dest;
    logic [N-1:0]      grant;
    logic              busy;
    logic [15:0]       pkt_cnt;

    logic [N-1:0]      s_tready4;
    logic [7:0]        m_tdata4;
    logic              m_tvalid4;
    logic              m_tlast4;
    logic [15:0]       m_dest4;
    logic [N-1:0]      grant4;
    logic              busy4;
    logic [3:0]        pkt_cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    udp_tx_arb #(.NUM_REQ(N), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .s_tdata_in(s_tdata), .s_tvalid_in(s_tvalid), .s_tlast_in(s_tlast),
        .s_dest_port_in(s_dest), .s_tready_out(s_tready),
        .m_tdata_out(m_tdata), .m_tvalid_out(m_tvalid), .m_tlast_out(m_tlast),
        .m_tready_in(m_tready), .m_dest_port_out(m_dest),
        .grant_out(grant), .busy_out(busy), .pkt_cnt_out(pkt_cnt)
    );

    udp_tx_arb #(.NUM_REQ(N), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .s_tdata_in(s_tdata), .s_tvalid_in(s_tvalid), .s_tlast_in(s_tlast),
        .s_dest_port_in(s_dest), .s_tready_out(s_tready4),
        .m_tdata_out(m_tdata4), .m_tvalid_out(m_tvalid4), .m_tlast_out(m_tlast4),
        .m_tready_in(m_tready), .m_dest_port_out(m_dest4),
        .grant_out(grant4), .busy_out(busy4), .pkt_cnt_out(pkt_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [7:0] d, input logic l);
        s_tvalid[i]       = v;
        s_tdata[8*i +: 8] = d;
        s_tlast[i]        = l;
    endtask

    task automatic do_reset();
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        reset    = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) s_dest[16*i +: 16] = 16'hA000 + 16'(i);
        do_reset();
        reset = 1'b1;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cnt", 32'(pkt_cnt), 32'h0);
        check("rst_dest", 32'(m_dest), 32'h0);
        check("rst_stream", {m_tdata, 6'd0, m_tvalid, m_tlast, 12'd0, s_tready}, 32'h0);
        step();
        reset = 1'b0;

        // Requesters 0 and 2 together: 0 first, 2 after one bubble
        drive(0, 1'b1, 8'hA0, 1'b0);
        drive(2, 1'b1, 8'hC0, 1'b1);
        #1;
        check("a_idle_grant", 32'(grant), 32'h0);
        check("a_idle_ready", 32'(s_tready), 32'h0);
        step();
        check("a_grant0", 32'(grant), 32'h1);
        check("a_dest0", 32'(m_dest), 32'hA000);
        check("a_busy", 32'(busy), 32'h1);
        check("a_b0", 32'(m_tdata), 32'hA0);
        check("a_rdy0", 32'(s_tready), 32'h1);
        s_dest[16*0 +: 16] = 16'hBEEF;
        step();
        drive(0, 1'b1, 8'hA1, 1'b0);
        #1;
        check("a_b1", 32'(m_tdata), 32'hA1);
        check("a_dest_hold", 32'(m_dest), 32'hA000);
        step();
        drive(0, 1'b1, 8'hA2, 1'b1);
        #1;
        check("a_b2", 32'(m_tdata), 32'hA2);
        check("a_last", 32'(m_tlast), 32'h1);
        step();
        s_dest[16*0 +: 16] = 16'hA000;
        drive(0, 1'b0, 8'h00, 1'b0);
        #1;
        check("a_bubble_grant", 32'(grant), 32'h0);
        check("a_bubble_valid", 32'(m_tvalid), 32'h0);
        check("a_cnt1", 32'(pkt_cnt), 32'h1);
        step();
        check("a_grant2", 32'(grant), 32'h4);
        check("a_dest2", 32'(m_dest), 32'hA002);
        check("a_c0", 32'(m_tdata), 32'hC0);
        step();
        drive(2, 1'b0, 8'h00, 1'b0);
        #1;
        check("a_cnt2", 32'(pkt_cnt), 32'h2);

        // Four requesters continuously valid, 2-byte packets
        do_reset();
        for (int i = 0; i < int'(N); i++) drive(i, 1'b1, 8'(i * 16), 1'b0);
        for (int p = 0; p < 5; p++) begin
            int r;
            r = p % int'(N);
            step();
            check($sformatf("rr_grant%0d", p), 32'(grant), 32'(1 << r));
            check($sformatf("rr_b0_%0d", p), 32'(m_tdata), 32'(r * 16));
            step();
            drive(r, 1'b1, 8'(r * 16 + 1), 1'b1);
            #1;
            check($sformatf("rr_b1_%0d", p), {m_tdata, 23'd0, m_tlast}, {8'(r * 16 + 1), 23'd0, 1'b1});
            step();
            drive(r, 1'b1, 8'(r * 16), 1'b0);
            #1;
            check($sformatf("rr_bubble%0d", p), 32'(grant), 32'h0);
        end
        check("rr_cnt5", 32'(pkt_cnt), 32'd5);
        check("rr_cnt5_w4", 32'(pkt_cnt4), 32'd5);

        // Backpressure toggling through a 4-byte packet
        do_reset();
        drive(1, 1'b1, 8'h50, 1'b0);
        step();
        begin
            int b;
            b = 0;
            for (int c = 0; c < 7; c++) begin
                logic rdy;
                rdy = (c % 2 == 0);
                m_tready = rdy;
                drive(1, 1'b1, 8'(8'h50 + b), (b == 3));
                #1;
                check($sformatf("bp_data%0d", c), 32'(m_tdata), 32'(8'h50 + b));
                check($sformatf("bp_rdy%0d", c), 32'(s_tready), rdy ? 32'h2 : 32'h0);
                if (rdy) b++;
                step();
            end
        end
        drive(1, 1'b0, 8'h00, 1'b0);
        m_tready = 1'b1;
        #1;
        check("bp_done_busy", 32'(busy), 32'h0);
        check("bp_cnt", 32'(pkt_cnt), 32'h1);

        // Granted requester stalls while requester 1 waits
        do_reset();
        drive(0, 1'b1, 8'h60, 1'b0);
        drive(1, 1'b1, 8'h70, 1'b1);
        step();
        check("st_grant0", 32'(grant), 32'h1);
        step();
        drive(0, 1'b0, 8'h61, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("st_valid%0d", c), 32'(m_tvalid), 32'h0);
            check($sformatf("st_hold%0d", c), 32'(grant), 32'h1);
            check($sformatf("st_rdy%0d", c), 32'(s_tready), 32'h1);
            step();
        end
        drive(0, 1'b1, 8'h61, 1'b0);
        #1;
        check("st_b1", 32'(m_tdata), 32'h61);
        step();
        drive(0, 1'b1, 8'h62, 1'b1);
        #1;
        check("st_b2_rdy", 32'(s_tready), 32'h1);
        step();
        drive(0, 1'b0, 8'h00, 1'b0);
        #1;
        check("st_bubble", 32'(grant), 32'h0);
        step();
        check("st_grant1", 32'(grant), 32'h2);
        check("st_dest1", 32'(m_dest), 32'hA001);
        step();
        drive(1, 1'b0, 8'h00, 1'b0);

        // Reset pulse in the middle of requester 3's packet
        do_reset();
        drive(3, 1'b1, 8'h80, 1'b0);
        step();
        check("rp_grant3", 32'(grant), 32'h8);
        step();
        drive(3, 1'b1, 8'h81, 1'b0);
        drive(1, 1'b1, 8'h90, 1'b1);
        drive(2, 1'b1, 8'hB0, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("rp_grant", 32'(grant), 32'h0);
        check("rp_stream", {m_tdata, 6'd0, m_tvalid, m_tlast, 12'd0, s_tready}, 32'h0);
        check("rp_busy_dest", {15'd0, busy, m_dest}, 32'h0);
        step();
        reset = 1'b0;
        step();
        check("rp_regrant", 32'(grant), 32'h2);
        check("rp_dest", 32'(m_dest), 32'hA001);

        // Single requester, single-beat packets back to back
        do_reset();
        drive(0, 1'b1, 8'h11, 1'b1);
        for (int p = 0; p < 17; p++) begin
            step();
            if (p == 0 || p == 16) begin
                check($sformatf("sb_grant%0d", p), 32'(grant), 32'h1);
                check($sformatf("sb_last%0d", p), 32'(m_tlast), 32'h1);
            end
            step();
            if (p == 0 || p == 16)
                check($sformatf("sb_bubble%0d", p), 32'(grant), 32'h0);
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        #1;
        check("sb_cnt17", 32'(pkt_cnt), 32'd17);
        check("sb_wrap", 32'(pkt_cnt4), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
